// File: rtl/rf_write_sched.sv
// Write-port scheduler for the 32x32 register file: an init pass writes INIT_VAL
// to every register, then requesters A and B share the single write port round-robin.
module rf_write_sched #(
  parameter int             NREG     = 32,
  parameter int             AW       = 5,
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_wn,
  input  logic [DW-1:0] a_wd,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic [AW-1:0] b_wn,
  input  logic [DW-1:0] b_wd,
  output logic          b_gnt,
  output logic          rf_w,
  output logic [AW-1:0] rf_wn,
  output logic [DW-1:0] rf_wd,
  output logic          init_busy,
  output logic [7:0]    stall_cnt
);

  // state   | meaning
  // ST_INIT | sweeping idx over every register, writing INIT_VAL; no grants
  // ST_ARB  | round-robin arbitration between A and B for the write port
  typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_t;
  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_t;

  state_t        state_q, state_d;
  rr_t           rr_last_q, rr_last_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          init_busy_q, init_busy_d;
  logic          rf_w_q, rf_w_d;
  logic [AW-1:0] rf_wn_q, rf_wn_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic [7:0]    stall_cnt_q, stall_cnt_d;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    idx_d       = idx_q;
    init_busy_d = init_busy_q;
    rf_w_d      = 1'b0;
    rf_wn_d     = rf_wn_q;
    rf_wd_d     = rf_wd_q;
    stall_cnt_d = stall_cnt_q;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;

    case (state_q)
      ST_INIT: begin
        rf_w_d  = 1'b1;
        rf_wn_d = idx_q;
        rf_wd_d = INIT_VAL;
        idx_d   = idx_q + 1'b1;
        if (idx_q == AW'(NREG - 1)) begin
          state_d     = ST_ARB;
          init_busy_d = 1'b0;
        end
      end

      ST_ARB: begin
        if (a_req && (!b_req || rr_last_q == RR_B))
          a_gnt = 1'b1;
        else if (b_req)
          b_gnt = 1'b1;

        // A write to register 0 is consumed but never reaches the rf.
        if (a_gnt) begin
          rr_last_d = RR_A;
          if (a_wn != '0) begin
            rf_w_d  = 1'b1;
            rf_wn_d = a_wn;
            rf_wd_d = a_wd;
          end
        end else if (b_gnt) begin
          rr_last_d = RR_B;
          if (b_wn != '0) begin
            rf_w_d  = 1'b1;
            rf_wn_d = b_wn;
            rf_wd_d = b_wd;
          end
        end

        if (((a_req && !a_gnt) || (b_req && !b_gnt)) && stall_cnt_q != 8'hFF)
          stall_cnt_d = stall_cnt_q + 8'd1;
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      rr_last_q   <= RR_B;
      idx_q       <= '0;
      init_busy_q <= 1'b1;
      rf_w_q      <= 1'b0;
      rf_wn_q     <= '0;
      rf_wd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      idx_q       <= idx_d;
      init_busy_q <= init_busy_d;
      rf_w_q      <= rf_w_d;
      rf_wn_q     <= rf_wn_d;
      rf_wd_q     <= rf_wd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_w      = rf_w_q;
  assign rf_wn     = rf_wn_q;
  assign rf_wd     = rf_wd_q;
  assign init_busy = init_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched; a small rf array captures the write stream
// so register contents can be compared against hand-computed values.
module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [4:0]  a_wn, b_wn;
  logic [31:0] a_wd, b_wd;
  logic        a_gnt, b_gnt;
  logic        rf_w;
  logic [4:0]  rf_wn;
  logic [31:0] rf_wd;
  logic        init_busy;
  logic [7:0]  stall_cnt;

  logic [31:0] rf_m [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_write_sched dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wn(a_wn), .a_wd(a_wd), .a_gnt(a_gnt),
    .b_req(b_req), .b_wn(b_wn), .b_wd(b_wd), .b_gnt(b_gnt),
    .rf_w(rf_w), .rf_wn(rf_wn), .rf_wd(rf_wd),
    .init_busy(init_busy), .stall_cnt(stall_cnt)
  );

  always @(posedge clk) if (rf_w) rf_m[rf_wn] <= rf_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_wn = '0; a_wd = '0;
    b_req = 1'b0; b_wn = '0; b_wd = '0;
    tick(); tick();
    chk("rst_rf_w", {31'd0, rf_w}, 0);
    chk("rst_busy", {31'd0, init_busy}, 1);
    chk("rst_stall", {24'd0, stall_cnt}, 0);
    chk("rst_wn", {27'd0, rf_wn}, 0);
    chk("rst_wd", rf_wd, 0);

    // init pass: edges 1..32 issue wn 0..31
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("init_w", {31'd0, rf_w}, 1);
      chk("init_wn", {27'd0, rf_wn}, k - 1);
      chk("init_wd", rf_wd, 0);
      chk("init_busy", {31'd0, init_busy}, (k < 32) ? 1 : 0);
    end
    tick();
    chk("post_init_w", {31'd0, rf_w}, 0);
    for (int i = 0; i < 32; i++) chk("init_rf", rf_m[i], 0);

    // dual requests: rr_last=B after reset so A goes first
    a_req = 1'b1; a_wn = 5'd3; a_wd = 32'd9;
    b_req = 1'b1; b_wn = 5'd4; b_wd = 32'd16;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("dual_agnt", {31'd0, a_gnt}, (n % 2 == 0) ? 1 : 0);
      chk("dual_bgnt", {31'd0, b_gnt}, (n % 2 == 1) ? 1 : 0);
      tick();
      chk("dual_w", {31'd0, rf_w}, 1);
      chk("dual_wn", {27'd0, rf_wn}, (n % 2 == 0) ? 3 : 4);
      chk("dual_wd", rf_wd, (n % 2 == 0) ? 9 : 16);
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("dual_stall", {24'd0, stall_cnt}, 4);
    tick(); tick();
    chk("dual_rf3", rf_m[3], 9);
    chk("dual_rf4", rf_m[4], 16);

    // single A request
    a_req = 1'b1; a_wn = 5'd5; a_wd = 32'd25;
    #1;
    chk("a_gnt", {31'd0, a_gnt}, 1);
    chk("a_bgnt", {31'd0, b_gnt}, 0);
    tick();
    a_req = 1'b0;
    chk("a_w", {31'd0, rf_w}, 1);
    chk("a_wn", {27'd0, rf_wn}, 5);
    chk("a_wd", rf_wd, 25);
    tick();
    chk("a_rf5", rf_m[5], 25);

    // B write to register 0 is granted but filtered
    b_req = 1'b1; b_wn = 5'd0; b_wd = 32'hFFFF_FFFF;
    #1;
    chk("x0_bgnt", {31'd0, b_gnt}, 1);
    tick();
    b_req = 1'b0;
    chk("x0_w", {31'd0, rf_w}, 0);
    tick();
    chk("x0_rf0", rf_m[0], 0);
    chk("x0_stall", {24'd0, stall_cnt}, 4);

    // reset during init at cycle 10
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("mid_wn", {27'd0, rf_wn}, 9);
    reset = 1'b1; tick();
    chk("mid_rst_w", {31'd0, rf_w}, 0);
    chk("mid_rst_busy", {31'd0, init_busy}, 1);
    reset = 1'b0;
    a_req = 1'b1; a_wn = 5'd7; a_wd = 32'd77;
    for (int k = 1; k <= 32; k++) begin
      #1;
      chk("mid_agnt", {31'd0, a_gnt}, 0);
      tick();
      chk("mid_w", {31'd0, rf_w}, 1);
      chk("mid_wn", {27'd0, rf_wn}, k - 1);
    end
    chk("mid_busy", {31'd0, init_busy}, 0);
    chk("mid_stall", {24'd0, stall_cnt}, 0);
    #1;
    chk("mid_agnt_arb", {31'd0, a_gnt}, 1);
    tick();
    a_req = 1'b0;
    chk("mid_a_w", {31'd0, rf_w}, 1);
    chk("mid_a_wn", {27'd0, rf_wn}, 7);
    chk("mid_a_wd", rf_wd, 77);

    // saturation under continuous dual requests
    a_req = 1'b1; a_wn = 5'd1; a_wd = 32'd11;
    b_req = 1'b1; b_wn = 5'd2; b_wd = 32'd22;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 254) chk("sat_254", {24'd0, stall_cnt}, 254);
      if (n == 255) chk("sat_255", {24'd0, stall_cnt}, 255);
    end
    chk("sat_end", {24'd0, stall_cnt}, 255);
    chk("sat_w", {31'd0, rf_w}, 1);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("sat_rf1", rf_m[1], 11);
    chk("sat_rf2", rf_m[2], 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
